// File: rtl/video_fifo_pkg.sv
// Shared constants and elaboration helpers for the video pipeline FIFO.
// Covers read-mode selection, the water-level width and the parameter legality check.
package video_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // water_level must represent 0..2^depth_width inclusive
    function automatic int level_width(input int depth_width);
        return depth_width + 1;
    endfunction

    function automatic bit fifo_params_ok(
        input int data_width,
        input int depth_width,
        input int fwft,
        input int almost_full_num,
        input int almost_empty_num
    );
        bit ok;
        ok = (data_width >= 1) && (data_width <= 1152) &&
             (depth_width >= 4) && (depth_width <= 20) &&
             ((fwft == FIFO_STD) || (fwft == FIFO_FWFT));
        if (ok) begin
            ok = (almost_full_num >= 1) && (almost_full_num <= (1 << depth_width) - 1) &&
                 (almost_empty_num >= 0) && (almost_empty_num <= (1 << depth_width) - 2);
        end
        return ok;
    endfunction

endpackage

// File: rtl/video_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
// The array carries no reset so it maps onto block RAM.
module video_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/video_sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, live water level,
// almost-full/empty thresholds, sticky overflow/underflow and a synchronous flush.
module video_sync_fifo
    import video_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH_WIDTH      = 12,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                wr_en,
    output logic                                wr_full,
    output logic                                almost_full,
    output logic [DATA_WIDTH-1:0]               rd_data,
    input  logic                                rd_en,
    output logic                                rd_empty,
    output logic                                almost_empty,
    output logic [level_width(DEPTH_WIDTH)-1:0] water_level,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int LW = level_width(DEPTH_WIDTH);
    localparam int PW = DEPTH_WIDTH + 1;
    localparam logic [LW-1:0] CAPACITY = {1'b1, {DEPTH_WIDTH{1'b0}}};

    if (!fifo_params_ok(DATA_WIDTH, DEPTH_WIDTH, FWFT, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM)) begin : g_param_check
        $fatal(1, "video_sync_fifo: illegal parameter set");
    end

    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic [LW-1:0]         level_next;
    logic                  wr_full_reg;
    logic                  almost_full_reg;
    logic                  almost_empty_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  rd_empty_int;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  ram_rd_en;
    logic                  ram_has_data;
    logic [DATA_WIDTH-1:0] ram_q;

    // flush wins over both requests, so nothing reaches the RAM on a flush cycle
    assign wr_accept    = wr_en & ~wr_full_reg & ~flush;
    assign rd_accept    = rd_en & ~rd_empty_int & ~flush;
    assign ram_has_data = (wr_ptr_reg != rd_ptr_reg);
    assign level_next   = level_reg + LW'(wr_accept) - LW'(rd_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            wr_full_reg      <= 1'b0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            wr_full_reg      <= 1'b0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (ram_rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            level_reg        <= level_next;
            wr_full_reg      <= (level_next == CAPACITY);
            almost_full_reg  <= (level_next >= LW'(ALMOST_FULL_NUM));
            almost_empty_reg <= (level_next <= LW'(ALMOST_EMPTY_NUM));
            overflow_reg     <= overflow_reg | (wr_en & wr_full_reg);
            underflow_reg    <= underflow_reg | (rd_en & rd_empty_int);
        end
    end

    video_sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(DEPTH_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_reg[DEPTH_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_reg[DEPTH_WIDTH-1:0]),
        .rd_data (ram_q)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // RAM read register acts as a middle stage feeding the output stage,
        // so a consumed head is replaced every cycle while words remain
        logic                  mid_valid_reg;
        logic                  out_valid_reg;
        logic [DATA_WIDTH-1:0] out_data_reg;
        logic                  mid_move;

        assign mid_move     = mid_valid_reg & (~out_valid_reg | rd_accept);
        assign ram_rd_en    = ram_has_data & (~mid_valid_reg | mid_move) & ~flush;
        assign rd_empty_int = ~out_valid_reg;
        assign rd_data      = out_data_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mid_valid_reg <= 1'b0;
                out_valid_reg <= 1'b0;
                out_data_reg  <= '0;
            end else if (flush) begin
                mid_valid_reg <= 1'b0;
                out_valid_reg <= 1'b0;
                out_data_reg  <= '0;
            end else begin
                if (ram_rd_en) begin
                    mid_valid_reg <= 1'b1;
                end else if (mid_move) begin
                    mid_valid_reg <= 1'b0;
                end
                if (mid_move) begin
                    out_data_reg  <= ram_q;
                    out_valid_reg <= 1'b1;
                end else if (rd_accept) begin
                    out_valid_reg <= 1'b0;
                end
            end
        end
    end else begin : g_std
        // RAM read register is the output; it reads as zero until the first read after clear
        logic rd_empty_reg;
        logic rd_zero_reg;

        assign ram_rd_en    = rd_accept & ram_has_data;
        assign rd_empty_int = rd_empty_reg;
        assign rd_data      = rd_zero_reg ? '0 : ram_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_empty_reg <= 1'b1;
                rd_zero_reg  <= 1'b1;
            end else if (flush) begin
                rd_empty_reg <= 1'b1;
                rd_zero_reg  <= 1'b1;
            end else begin
                rd_empty_reg <= (level_next == '0);
                if (rd_accept) begin
                    rd_zero_reg <= 1'b0;
                end
            end
        end
    end

    assign wr_full      = wr_full_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign rd_empty     = rd_empty_int;
    assign water_level  = level_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_video_sync_fifo.sv
// Randomised scoreboard bench driving a standard-mode and an FWFT-mode FIFO with shared stimulus.
module tb_video_sync_fifo;

    localparam int CAP = 4096;

    logic        clk;
    logic        tb_rst;
    logic        tb_flush;
    logic        tb_wr_en;
    logic        tb_rd_en;
    logic [7:0]  tb_wr_data;

    logic        std_wr_full, std_almost_full, std_rd_empty, std_almost_empty, std_overflow, std_underflow;
    logic [7:0]  std_rd_data;
    logic [12:0] std_level;
    logic        fw_wr_full, fw_almost_full, fw_rd_empty, fw_almost_empty, fw_overflow, fw_underflow;
    logic [7:0]  fw_rd_data;
    logic [12:0] fw_level;

    video_sync_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(12), .FWFT(0),
                      .ALMOST_FULL_NUM(1020), .ALMOST_EMPTY_NUM(4)) u_std (
        .clk(clk), .rst(tb_rst), .flush(tb_flush),
        .wr_data(tb_wr_data), .wr_en(tb_wr_en), .wr_full(std_wr_full), .almost_full(std_almost_full),
        .rd_data(std_rd_data), .rd_en(tb_rd_en), .rd_empty(std_rd_empty), .almost_empty(std_almost_empty),
        .water_level(std_level), .overflow(std_overflow), .underflow(std_underflow)
    );

    video_sync_fifo #(.DATA_WIDTH(8), .DEPTH_WIDTH(12), .FWFT(1),
                      .ALMOST_FULL_NUM(1020), .ALMOST_EMPTY_NUM(4)) u_fwft (
        .clk(clk), .rst(tb_rst), .flush(tb_flush),
        .wr_data(tb_wr_data), .wr_en(tb_wr_en), .wr_full(fw_wr_full), .almost_full(fw_almost_full),
        .rd_data(fw_rd_data), .rd_en(tb_rd_en), .rd_empty(fw_rd_empty), .almost_empty(fw_almost_empty),
        .water_level(fw_level), .overflow(fw_overflow), .underflow(fw_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference contents; FWFT entries carry the edge index of their write
    logic [7:0] s_q[$];
    logic [7:0] f_q[$];
    int         f_t[$];
    bit s_ovf = 0, s_unf = 0, f_ovf = 0, f_unf = 0;

    // expected read-out order consumed by the monitor
    logic [7:0] sb_std[$];
    logic [7:0] sb_fw[$];
    bit std_pend = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // FWFT head is readable once two edges have passed since it was written
    function automatic bit fw_avail(input int edge_idx);
        return (f_q.size() != 0) && (f_t[0] <= edge_idx - 2);
    endfunction

    task automatic check_flags();
        int sn;
        int fn;
        sn = s_q.size();
        fn = f_q.size();
        chk("std_level",        int'(std_level),        sn);
        chk("std_rd_empty",     int'(std_rd_empty),     int'(sn == 0));
        chk("std_wr_full",      int'(std_wr_full),      int'(sn == CAP));
        chk("std_almost_full",  int'(std_almost_full),  int'(sn >= 1020));
        chk("std_almost_empty", int'(std_almost_empty), int'(sn <= 4));
        chk("std_overflow",     int'(std_overflow),     int'(s_ovf));
        chk("std_underflow",    int'(std_underflow),    int'(s_unf));
        chk("fw_level",         int'(fw_level),         fn);
        chk("fw_rd_empty",      int'(fw_rd_empty),      int'(!fw_avail(cyc)));
        chk("fw_wr_full",       int'(fw_wr_full),       int'(fn == CAP));
        chk("fw_almost_full",   int'(fw_almost_full),   int'(fn >= 1020));
        chk("fw_almost_empty",  int'(fw_almost_empty),  int'(fn <= 4));
        chk("fw_overflow",      int'(fw_overflow),      int'(f_ovf));
        chk("fw_underflow",     int'(fw_underflow),     int'(f_unf));
    endtask

    task automatic clear_model();
        s_q.delete(); f_q.delete(); f_t.delete();
        s_ovf = 0; s_unf = 0; f_ovf = 0; f_unf = 0;
    endtask

    // one clock edge: update the model from the current inputs, then check after the edge
    task automatic step();
        bit f_empty_pre, s_wr, s_rd, f_wr, f_rd, flushed;
        cyc++;
        flushed = tb_flush;
        f_empty_pre = !fw_avail(cyc - 1);
        if (tb_flush) begin
            clear_model();
        end else begin
            if (tb_wr_en && s_q.size() == CAP) s_ovf = 1;
            if (tb_rd_en && s_q.size() == 0)   s_unf = 1;
            if (tb_wr_en && f_q.size() == CAP) f_ovf = 1;
            if (tb_rd_en && f_empty_pre)       f_unf = 1;
            s_wr = tb_wr_en && (s_q.size() < CAP);
            s_rd = tb_rd_en && (s_q.size() != 0);
            f_wr = tb_wr_en && (f_q.size() < CAP);
            f_rd = tb_rd_en && !f_empty_pre;
            if (s_rd) void'(s_q.pop_front());
            if (f_rd) begin
                void'(f_q.pop_front());
                void'(f_t.pop_front());
            end
            if (s_wr) begin
                s_q.push_back(tb_wr_data);
                sb_std.push_back(tb_wr_data);
            end
            if (f_wr) begin
                f_q.push_back(tb_wr_data);
                f_t.push_back(cyc);
                sb_fw.push_back(tb_wr_data);
            end
        end
        @(posedge clk);
        #1;
        if (flushed) begin
            sb_std.delete();
            sb_fw.delete();
        end
        check_flags();
    endtask

    task automatic drive(input bit w, input bit r, input logic [7:0] d, input bit f);
        tb_wr_en = w;
        tb_rd_en = r;
        tb_wr_data = d;
        tb_flush = f;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // asynchronous reset applied between edges, checked before the next edge
    task automatic do_reset();
        tb_rst = 1'b1;
        #2;
        clear_model();
        check_flags();
        chk("rst_std_rd_data", int'(std_rd_data), 0);
        chk("rst_fw_rd_data",  int'(fw_rd_data),  0);
        @(posedge clk);
        #1;
        tb_rst = 1'b0;
        sb_std.delete();
        sb_fw.delete();
    endtask

    always @(negedge clk) begin
        if (!tb_rst) begin
            if (std_pend) begin
                if (sb_std.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL std_sb_underrun cyc=%0d actual=%0d required=none", cyc, std_rd_data);
                end else begin
                    chk("std_rd_data", int'(std_rd_data), int'(sb_std.pop_front()));
                end
            end
            if (tb_rd_en && !fw_rd_empty && !tb_flush) begin
                if (sb_fw.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fw_sb_underrun cyc=%0d actual=%0d required=none", cyc, fw_rd_data);
                end else begin
                    chk("fw_rd_data", int'(fw_rd_data), int'(sb_fw.pop_front()));
                end
            end
        end
        std_pend <= !tb_rst && tb_rd_en && !std_rd_empty && !tb_flush;
    end

    initial begin
        tb_rst = 1'b1;
        tb_flush = 1'b0;
        tb_wr_en = 1'b0;
        tb_rd_en = 1'b0;
        tb_wr_data = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // empty boundary: read on empty, then a write
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'hA5, 1'b0);
        idle();
        idle();
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // fill to capacity, overflow, full with simultaneous read, drain
        for (int i = 0; i < CAP; i++) drive(1'b1, 1'b0, 8'(255 - i), 1'b0);
        drive(1'b1, 1'b0, 8'h77, 1'b0);
        drive(1'b1, 1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < CAP + 2; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        // FWFT single word latency
        drive(1'b1, 1'b0, 8'h5A, 1'b0);
        idle();
        idle();
        chk("fw_5a_data",  int'(fw_rd_data),  8'h5A);
        chk("fw_5a_empty", int'(fw_rd_empty), 0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);

        // eight queued words read back to back
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom), 1'b0);
        idle();
        idle();
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        idle();

        // steady state at level 100 across pointer wrap
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, 8'($urandom), 1'b0);
        idle();
        idle();
        for (int i = 0; i < 5000; i++) drive(1'b1, 1'b1, 8'($urandom), 1'b0);
        chk("steady_std_level", int'(std_level), 100);
        chk("steady_fw_level",  int'(fw_level),  100);

        // random traffic with occasional flush
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < (i < 1500 ? 70 : 35),
                  $urandom_range(0, 99) < 50,
                  8'($urandom),
                  $urandom_range(0, 299) == 0);
        end

        // flush mid-burst at level 37
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 37; i++) drive(1'b1, 1'b0, 8'(i + 1), 1'b0);
        chk("pre_flush_level", int'(std_level), 37);
        drive(1'b1, 1'b1, 8'hCC, 1'b1);
        chk("flush_std_rd_data", int'(std_rd_data), 0);
        chk("flush_fw_rd_data",  int'(fw_rd_data),  0);
        drive(1'b1, 1'b0, 8'h11, 1'b0);
        idle();
        idle();
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        idle();

        // reset mid-burst at level 37 with writes still requested
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 37; i++) drive(1'b1, 1'b0, 8'(i + 64), 1'b0);
        do_reset();
        drive(1'b1, 1'b0, 8'h22, 1'b0);
        idle();
        idle();
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
